ifu_fetch: RTL and testbench

//  Instruction fetch stage of the multi-cycle NPC core; sits directly upstream of the decode stage.

---
 rtl/npc_pkg.sv | 25 ++
 rtl/ifu_perf_cnt.sv | 40 ++++
 rtl/ifu_fetch.sv | 117 +++++++++++
 tb/tb_ifu_fetch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: shared types and constants for the NPC core front end.
//   ifu_state_t      - fetch-stage FSM states
//   ifu_out_t        - instruction payload held toward decode
//   NOP_INST         - instruction substituted on faults and reset (addi x0,x0,0)
//   RESET_PC_DEFAULT - default architectural reset PC
package npc_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0]       RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_RSP,
    S_OUT,
    S_WAIT_NPC
  } ifu_state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic              fault;
  } ifu_out_t;

endpackage

// File: rtl/ifu_perf_cnt.sv
// ifu_perf_cnt: fetch-stage performance counters (64-bit, wrap at 2^64).
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   fetch_inc_i   - one instruction handed to decode this cycle
//   stall_inc_i   - fetch stage waiting on memory this cycle
//   fetch_cnt_o   - count of decode handshakes
//   stall_cnt_o   - count of memory-wait cycles
module ifu_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc_i,
  input  logic        stall_inc_i,
  output logic [63:0] fetch_cnt_o,
  output logic [63:0] stall_cnt_o
);

  logic [63:0] fetch_cnt_q, fetch_cnt_d;
  logic [63:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_inc_i) fetch_cnt_d = fetch_cnt_q + 64'd1;
    if (stall_inc_i) stall_cnt_d = stall_cnt_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage of the multi-cycle NPC core.
// Owns the PC, issues one word read per instruction, hands {inst,pc,fault}
// to decode, then waits for the next PC from execute/writeback.
// Optional feature macro: IFU_PERF_CNT_EN (adds perf_fetch_cnt/perf_stall_cnt).
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   imem_req_valid/ready/addr      - fetch request channel
//   imem_rsp_valid/ready/data/err  - read response channel
//   ifu_valid/ifu_ready            - handshake toward decode
//   inst, pc, ifu_fault            - payload toward decode
//   npc_valid, npc                 - next PC from the retire path
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [WIDTH-1:0]  imem_req_addr,
  input  logic              imem_rsp_valid,
  output logic              imem_rsp_ready,
  input  logic [31:0]       imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              ifu_valid,
  input  logic              ifu_ready,
  output logic [31:0]       inst,
  output logic [WIDTH-1:0]  pc,
  output logic              ifu_fault,
  input  logic              npc_valid,
  input  logic [WIDTH-1:0]  npc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_stall_cnt
`endif
);

  ifu_state_t       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  ifu_out_t         out_q, out_d;
  logic             req_valid_q, req_valid_d;

  // Next-state and payload update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;
    unique case (state_q)
      S_REQ: begin
        if (pc_q[1:0] != 2'b00) begin
          // Misaligned PC: report a fault without touching the bus.
          out_d.inst  = NOP_INST;
          out_d.fault = 1'b1;
          state_d     = S_OUT;
        end else if (req_valid_q && imem_req_ready) begin
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (imem_rsp_valid) begin
          out_d.inst  = imem_rsp_err ? NOP_INST : imem_rsp_data;
          out_d.fault = imem_rsp_err;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (ifu_ready) state_d = S_WAIT_NPC;
      end
      S_WAIT_NPC: begin
        if (npc_valid) begin
          pc_d    = npc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    // Request valid is registered from the next state so it is stable while stalled.
    req_valid_d = (state_d == S_REQ) && (pc_d[1:0] == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      out_q       <= '{inst: NOP_INST, fault: 1'b0};
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_q       <= out_d;
      req_valid_q <= req_valid_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign imem_rsp_ready = (state_q == S_RSP);
  assign ifu_valid      = (state_q == S_OUT);
  assign inst           = out_q.inst;
  assign pc             = pc_q;
  assign ifu_fault      = out_q.fault;

`ifdef IFU_PERF_CNT_EN
  ifu_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .fetch_inc_i (ifu_valid && ifu_ready),
    .stall_inc_i ((state_q == S_REQ) || (state_q == S_RSP)),
    .fetch_cnt_o (perf_fetch_cnt),
    .stall_cnt_o (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: self-checking bench for ifu_fetch.
// Table of fetch transactions (memory/decode wait cycles, response, next PC)
// plus hand-written reset-mid-transaction sequences.
module tb_ifu_fetch;
  import npc_pkg::*;

  localparam int unsigned W   = 32;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic          clk;
  logic          rst;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [W-1:0]  imem_req_addr;
  logic          imem_rsp_valid;
  logic          imem_rsp_ready;
  logic [31:0]   imem_rsp_data;
  logic          imem_rsp_err;
  logic          ifu_valid;
  logic          ifu_ready;
  logic [31:0]   inst;
  logic [W-1:0]  pc;
  logic          ifu_fault;
  logic          npc_valid;
  logic [W-1:0]  npc;
`ifdef IFU_PERF_CNT_EN
  logic [63:0]   perf_fetch_cnt;
  logic [63:0]   perf_stall_cnt;
`endif

  ifu_fetch #(.WIDTH(W), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .ifu_valid      (ifu_valid),
    .ifu_ready      (ifu_ready),
    .inst           (inst),
    .pc             (pc),
    .ifu_fault      (ifu_fault),
    .npc_valid      (npc_valid),
    .npc            (npc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_req_hs = 0;
  int n_ifu_hs = 0;

  // Handshake counters observed on the clock edge.
  always @(posedge clk) begin
    if (!rst && imem_req_valid && imem_req_ready) n_req_hs++;
    if (!rst && ifu_valid && ifu_ready) n_ifu_hs++;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
    int          req_wait;
    int          out_wait;
    logic [31:0] npc;
    logic [31:0] exp_inst;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    int k = 0;
    while (!imem_req_valid && k < 5) begin
      step();
      k++;
    end
    chk("req_valid_after_reset", 64'(imem_req_valid), 64'd1);
  endtask

  // One full fetch: request, response, decode handshake, next PC.
  task automatic run_vec(input vec_t v);
    int req0 = n_req_hs;
    int ifu0 = n_ifu_hs;
    logic aligned = (v.pc[1:0] == 2'b00);
    chk("pc_at_req", 64'(pc), 64'(v.pc));
    if (aligned) begin
      chk("req_valid", 64'(imem_req_valid), 64'd1);
      chk("req_addr", 64'(imem_req_addr), 64'(v.pc));
      for (int i = 0; i < v.req_wait; i++) begin
        step();
        chk("req_valid_stall", 64'(imem_req_valid), 64'd1);
        chk("req_addr_stall", 64'(imem_req_addr), 64'(v.pc));
        chk("rsp_ready_stall", 64'(imem_rsp_ready), 64'd0);
      end
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      chk("rsp_ready", 64'(imem_rsp_ready), 64'd1);
      chk("req_valid_drop", 64'(imem_req_valid), 64'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = v.data;
      imem_rsp_err   = v.err;
      step();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_rsp_err   = 1'b0;
    end else begin
      chk("misaligned_no_req", 64'(imem_req_valid), 64'd0);
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
    end
    for (int i = 0; i <= v.out_wait; i++) begin
      chk("ifu_valid", 64'(ifu_valid), 64'd1);
      chk("inst", 64'(inst), 64'(v.exp_inst));
      chk("pc_out", 64'(pc), 64'(v.pc));
      chk("ifu_fault", 64'(ifu_fault), 64'(v.exp_fault));
      if (i == v.out_wait) ifu_ready = 1'b1;
      step();
    end
    ifu_ready = 1'b0;
    chk("ifu_valid_after_hs", 64'(ifu_valid), 64'd0);
    chk("req_in_wait_npc", 64'(imem_req_valid), 64'd0);
    chk("req_hs_count", 64'(n_req_hs - req0), aligned ? 64'd1 : 64'd0);
    chk("ifu_hs_count", 64'(n_ifu_hs - ifu0), 64'd1);
    npc_valid = 1'b1;
    npc       = v.npc;
    step();
    npc_valid = 1'b0;
    npc       = 32'h0;
    chk("req_after_npc", 64'(imem_req_valid), (v.npc[1:0] == 2'b00) ? 64'd1 : 64'd0);
  endtask

  initial begin
`ifdef IFU_PERF_CNT_EN
    logic [63:0] f0, s0;
    logic [63:0] exp_stall;
`endif
    vec_t fin;
    //          pc            data          err  rw ow npc           exp_inst      flt
    vecs[0] = '{32'h8000_0000, 32'h0010_0093, 1'b0, 0, 0, 32'h8000_0004, 32'h0010_0093, 1'b0};
    vecs[1] = '{32'h8000_0004, 32'h0020_0113, 1'b0, 3, 2, 32'h8000_0008, 32'h0020_0113, 1'b0};
    vecs[2] = '{32'h8000_0008, 32'hDEAD_BEEF, 1'b1, 0, 0, 32'h8000_000C, 32'h0000_0013, 1'b1};
    vecs[3] = '{32'h8000_000C, 32'h0030_0193, 1'b0, 0, 0, 32'h8000_0002, 32'h0030_0193, 1'b0};
    vecs[4] = '{32'h8000_0002, 32'h0000_0000, 1'b0, 0, 1, 32'h8000_0010, 32'h0000_0013, 1'b1};
    vecs[5] = '{32'h8000_0010, 32'h1234_5678, 1'b0, 1, 1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0};
    vecs[6] = '{32'hFFFF_FFFC, 32'hAABB_CCDD, 1'b0, 2, 0, 32'h0000_0000, 32'hAABB_CCDD, 1'b0};
    vecs[7] = '{32'h0000_0000, 32'h0040_0213, 1'b0, 0, 3, 32'h8000_0000, 32'h0040_0213, 1'b0};
    fin     = '{32'h8000_0000, 32'h0050_0293, 1'b0, 0, 0, 32'h8000_0004, 32'h0050_0293, 1'b0};

    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    ifu_ready      = 1'b0;
    npc_valid      = 1'b0;
    npc            = 32'h0;
    repeat (3) step();
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_rsp_ready", 64'(imem_rsp_ready), 64'd0);
    chk("rst_ifu_valid", 64'(ifu_valid), 64'd0);
    chk("rst_pc", 64'(pc), 64'(RPC));
    chk("rst_inst", 64'(inst), 64'h13);
    chk("rst_fault", 64'(ifu_fault), 64'd0);
`ifdef IFU_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 64'd0);
    chk("rst_perf_stall", perf_stall_cnt, 64'd0);
`endif
    rst = 1'b0;
    wait_req();

`ifdef IFU_PERF_CNT_EN
    f0 = perf_fetch_cnt;
    s0 = perf_stall_cnt;
    exp_stall = 64'd0;
`endif
    for (int i = 0; i < 8; i++) begin
`ifdef IFU_PERF_CNT_EN
      exp_stall += (vecs[i].pc[1:0] == 2'b00) ? 64'(vecs[i].req_wait + 2) : 64'd1;
`endif
      run_vec(vecs[i]);
    end
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetch_delta", perf_fetch_cnt - f0, 64'd8);
    chk("perf_stall_delta", perf_stall_cnt - s0, exp_stall);
`endif

    // Reset while waiting for the response.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("pre_rst_rsp_ready", 64'(imem_rsp_ready), 64'd1);
    rst = 1'b1;
    step();
    chk("rst_rsp_ifu_valid", 64'(ifu_valid), 64'd0);
    chk("rst_rsp_rsp_ready", 64'(imem_rsp_ready), 64'd0);
    chk("rst_rsp_pc", 64'(pc), 64'(RPC));
    chk("rst_rsp_req_valid", 64'(imem_req_valid), 64'd0);
    rst = 1'b0;
    wait_req();
    chk("rst_rsp_addr", 64'(imem_req_addr), 64'(RPC));

    // Reset while presenting a faulted instruction to decode.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    imem_rsp_err   = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    chk("pre_rst_out_valid", 64'(ifu_valid), 64'd1);
    chk("pre_rst_out_fault", 64'(ifu_fault), 64'd1);
    rst = 1'b1;
    step();
    chk("rst_out_ifu_valid", 64'(ifu_valid), 64'd0);
    chk("rst_out_fault", 64'(ifu_fault), 64'd0);
    chk("rst_out_inst", 64'(inst), 64'h13);
    rst = 1'b0;
    wait_req();
    run_vec(fin);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
